// File: rtl/amiga_reset_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | amiga_reset_ctl                                                          |
// | Open-drain _RST controller: stretches power, external, keyboard and soft |
// | resets, then exports a clean reset and its cause.                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module amiga_reset_ctl #(
  parameter int MIN_PULSE   = 64,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16,
  parameter int HOLDOFF     = 8
) (
  input  logic       C7M,
  input  logic       _PWRRST,
  input  logic       RST_IN,
  output logic       RST_OE,
  input  logic       _KBRST,
  input  logic       SOFT_REQ,
  output logic       RST_ACTIVE,
  output logic [1:0] RST_CAUSE,
  output logic       BUSY
);

  localparam int CNT_MAX = (MIN_PULSE > HOLDOFF) ? MIN_PULSE : HOLDOFF;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DEB_W   = $clog2(DEB_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_TOP    = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(MIN_PULSE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF - 1);
  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);

  localparam logic [1:0] CAUSE_PWR  = 2'd0;
  localparam logic [1:0] CAUSE_EXT  = 2'd1;
  localparam logic [1:0] CAUSE_KB   = 2'd2;
  localparam logic [1:0] CAUSE_SOFT = 2'd3;

  typedef enum logic [2:0] {
    S_PWRUP   = 3'd0,
    S_IDLE    = 3'd1,
    S_DRIVE   = 3'd2,
    S_EXT     = 3'd3,
    S_RELEASE = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] rst_sync_q, rst_sync_d;
  logic [SYNC_STAGES-1:0] kb_sync_q, kb_sync_d;
  logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic                   kb_deb_q, kb_deb_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             cause_q, cause_d;
  logic                   oe_q, oe_d;
  logic                   active_q, active_d;
  logic                   busy_q, busy_d;
  logic                   rst_line;
  logic                   kb_line;

  assign rst_line = rst_sync_q[SYNC_STAGES-1];
  assign kb_line  = kb_sync_q[SYNC_STAGES-1];

  // The debounced level only follows after DEB_CYCLES consecutive disagreeing samples.
  always_comb begin
    rst_sync_d = {rst_sync_q[SYNC_STAGES-2:0], RST_IN};
    kb_sync_d  = {kb_sync_q[SYNC_STAGES-2:0], _KBRST};
    kb_deb_d   = kb_deb_q;
    deb_cnt_d  = '0;
    if (kb_line != kb_deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        kb_deb_d = kb_line;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + CNT_W'(1);
    case (state_q)
      S_PWRUP: begin
        if (cnt_q >= PULSE_LAST) state_d = S_RELEASE;
      end
      S_IDLE: begin
        if (!rst_line) begin
          state_d = S_EXT;
          cause_d = CAUSE_EXT;
        end else if (!kb_deb_q) begin
          state_d = S_DRIVE;
          cause_d = CAUSE_KB;
        end else if (SOFT_REQ) begin
          state_d = S_DRIVE;
          cause_d = CAUSE_SOFT;
        end
      end
      S_EXT: begin
        if (cnt_q >= PULSE_LAST) state_d = S_RELEASE;
      end
      S_DRIVE: begin
        // A held keyboard keeps the line driven past the minimum pulse.
        if ((cnt_q >= PULSE_LAST) && !((cause_q == CAUSE_KB) && !kb_deb_q)) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (rst_line) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q >= HOLD_LAST) state_d = S_IDLE;
      end
      default: begin
        state_d = S_PWRUP;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
    oe_d     = (state_d == S_PWRUP) || (state_d == S_EXT) || (state_d == S_DRIVE);
    active_d = (state_d != S_IDLE);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge C7M or negedge _PWRRST) begin
    if (!_PWRRST) begin
      rst_sync_q <= '1;
      kb_sync_q  <= '1;
      deb_cnt_q  <= '0;
      kb_deb_q   <= 1'b1;
      state_q    <= S_PWRUP;
      cnt_q      <= '0;
      cause_q    <= CAUSE_PWR;
      oe_q       <= 1'b1;
      active_q   <= 1'b1;
      busy_q     <= 1'b1;
    end else begin
      rst_sync_q <= rst_sync_d;
      kb_sync_q  <= kb_sync_d;
      deb_cnt_q  <= deb_cnt_d;
      kb_deb_q   <= kb_deb_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cause_q    <= cause_d;
      oe_q       <= oe_d;
      active_q   <= active_d;
      busy_q     <= busy_d;
    end
  end

  assign RST_OE     = oe_q;
  assign RST_ACTIVE = active_q;
  assign RST_CAUSE  = cause_q;
  assign BUSY       = busy_q;

endmodule
`default_nettype wire
